// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction-fetch queue.
// Optional same-cycle response bypass is enabled with IFQ_BYPASS_EN.
package ifq_pkg;

  localparam int ILEN        = 32;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ifq_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  // Address of the next sequential instruction; wraps silently at the top of memory.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return align_pc(pc) + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry FIFO of {pc, instr} pairs with push, pop, flush and occupancy.
// Push and pop together while full is legal and leaves the count unchanged.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  ifq_entry_t       entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output ifq_entry_t       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  ifq_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: non-blocking assignments throughout sequential logic so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (!push_i && pop_i) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifetch_queue.sv
// RV32 fetch front end: owns the fetch PC, issues credit-limited requests and queues responses.
// Define IFQ_BYPASS_EN to let a response reach decode in its arrival cycle when the queue is empty.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter  int                ADDR_W          = 32,
  parameter  logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(32'h0000_0000),
  parameter  int                DEPTH           = 4,
  parameter  int                MAX_OUTSTANDING = 4,
  localparam int                CNT_W           = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [ILEN-1:0]   imem_resp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ILEN-1:0]   out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [CNT_W-1:0]  out_count
);

  localparam int OS_W = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [OS_W-1:0]   outstanding_q, outstanding_d;
  logic [OS_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              fifo_push, fifo_pop;
  ifq_entry_t        fifo_head, resp_entry;

  logic              credit_ok, req_fire;
  logic              resp_drop, resp_keep;
  logic              bypass_valid, bypass_take;
  logic [XLEN-1:0]   redirect_full, fetch_pc_inc, resp_pc_inc;
  logic [ADDR_W-1:0] redirect_target;

  assign redirect_full   = align_pc(XLEN'(redirect_pc));
  assign redirect_target = redirect_full[ADDR_W-1:0];
  assign fetch_pc_inc    = next_pc(XLEN'(fetch_pc_q));
  assign resp_pc_inc     = next_pc(XLEN'(resp_pc_q));

  // Reserving a queue slot per request means responses never need backpressure.
  assign credit_ok = (int'(outstanding_q) < MAX_OUTSTANDING) &&
                     ((int'(fifo_count) + int'(outstanding_q)) < DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_drop        = (drop_cnt_q != '0);
  assign resp_keep        = imem_resp_valid && !resp_drop && !redirect_valid;
  assign resp_entry.pc    = XLEN'(resp_pc_q);
  assign resp_entry.instr = imem_resp_data;

`ifdef IFQ_BYPASS_EN
  assign bypass_valid = resp_keep && fifo_empty;
`else
  assign bypass_valid = 1'b0;
`endif
  assign bypass_take = bypass_valid && out_ready;

  assign fifo_push = resp_keep && !bypass_take;
  assign fifo_pop  = out_ready && !fifo_empty && !redirect_valid;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + OS_W'(req_fire) - OS_W'(imem_resp_valid);
    if (redirect_valid) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      // Everything still in flight after this cycle is stale, including responses
      // already marked for dropping, so the new drop count is simply what remains.
      drop_cnt_d = (outstanding_q == '0) ? '0 : outstanding_q - OS_W'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_inc[ADDR_W-1:0];
      if (imem_resp_valid) begin
        if (resp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
        else           resp_pc_d  = resp_pc_inc[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .entry_i (resp_entry),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    out_valid = !fifo_empty || bypass_valid;
    out_instr = fifo_head.instr;
    out_pc    = fifo_head.pc[ADDR_W-1:0];
    if (fifo_empty) begin
      out_instr = bypass_valid ? resp_entry.instr : '0;
      out_pc    = bypass_valid ? resp_pc_q : RESET_PC;
    end
  end

  assign out_count = fifo_count;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_resp_valid && outstanding_q == '0))
        else $error("ifetch_queue: response with no request outstanding");
      assert (!(fifo_push && fifo_full && !fifo_pop))
        else $error("ifetch_queue: push while queue full");
      assert (!(fifo_pop && fifo_empty))
        else $error("ifetch_queue: pop while queue empty");
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue against an epoch-tagged memory and queue model.
// Built for the default configuration (IFQ_BYPASS_EN undefined).
module tb_ifetch_queue;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  out_count;

  always #5 clk = ~clk;

  ifetch_queue #(
    .ADDR_W          (32),
    .RESET_PC        (32'h0000_0000),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_count       (out_count)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } flight_t;

  flight_t     inflight[$];
  logic [31:0] mq[$];
  logic [31:0] fetch_m;
  int          epoch, cyc, last_due;
  int          lat_lo, lat_hi, ready_pct, oready_pct;
  int          n_tests, n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit resp_due();
    return (inflight.size() != 0) && (inflight[0].due <= cyc);
  endfunction

  // One clock cycle: entered and left just after a falling edge.
  task automatic step(input logic rd, input logic [31:0] rd_pc);
    flight_t e;
    bit      exp_rv, rv, pop_m, fire, keep;
    int      lat, due;
    rv              = resp_due();
    imem_resp_valid = rv;
    imem_resp_data  = rv ? (inflight[0].addr ^ KEY) : 32'h0;
    redirect_valid  = rd;
    redirect_pc     = rd_pc;
    imem_req_ready  = ($urandom_range(99) < ready_pct);
    out_ready       = ($urandom_range(99) < oready_pct);
    #1;
    exp_rv = !rd && (inflight.size() < MAXO) && ((mq.size() + inflight.size()) < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("req_addr", imem_req_addr, fetch_m);
    check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("out_count", 32'(out_count), 32'(mq.size()));
    if (mq.size() != 0) begin
      check("out_pc", out_pc, mq[0]);
      check("out_instr", out_instr, mq[0] ^ KEY);
    end
    pop_m = (mq.size() != 0) && out_ready && !rd;
    fire  = exp_rv && imem_req_ready;
    keep  = 1'b0;
    if (rv) begin
      e    = inflight.pop_front();
      keep = !rd && (e.epoch == epoch);
    end
    if (rd) begin
      mq.delete();
      epoch++;
      fetch_m = {rd_pc[31:2], 2'b00};
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (keep)  mq.push_back(e.addr);
    end
    if (fire) begin
      lat = $urandom_range(lat_hi, lat_lo);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      inflight.push_back('{addr: fetch_m, epoch: epoch, due: due});
      fetch_m = fetch_m + 32'd4;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string phase);
    check({phase, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    check({phase, "_req_addr"},  imem_req_addr, 32'h0);
    check({phase, "_out_valid"}, 32'(out_valid), 32'h0);
    check({phase, "_out_instr"}, out_instr, 32'h0);
    check({phase, "_out_pc"},    out_pc, 32'h0);
    check({phase, "_out_count"}, 32'(out_count), 32'h0);
  endtask

  task automatic set_mode(input int lo, input int hi, input int rp, input int op);
    lat_lo = lo; lat_hi = hi; ready_pct = rp; oready_pct = op;
  endtask

  // Runs until the model queue holds something, then checks the DUT head PC.
  task automatic expect_first_pc(input string tag, input logic [31:0] pc);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() != 0) found = 1'b1;
      else step(1'b0, 32'h0);
    end
    check({tag, "_seen"}, 32'(found), 32'h1);
    if (found) begin
      #1;
      check(tag, out_pc, pc);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    epoch = 0; cyc = 0; last_due = 0; fetch_m = 32'h0;
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;

    // Streaming with single-cycle memory and decode always ready.
    set_mode(1, 1, 100, 100);
    repeat (30) step(1'b0, 32'h0);

    // Decode stalls: queue fills, requests stop, then drain contiguously.
    set_mode(1, 1, 100, 0);
    repeat (20) step(1'b0, 32'h0);
    #1;
    check("stall_count", 32'(out_count), 32'd4);
    check("stall_req_valid", 32'(imem_req_valid), 32'h0);
    set_mode(1, 1, 100, 100);
    repeat (20) step(1'b0, 32'h0);

    // Three-cycle memory latency.
    set_mode(3, 3, 100, 100);
    repeat (40) step(1'b0, 32'h0);

    // Redirect with three requests in flight.
    begin
      bit ready3 = 1'b0;
      for (int i = 0; i < 20 && !ready3; i++) begin
        if (inflight.size() == 3) ready3 = 1'b1;
        else step(1'b0, 32'h0);
      end
      check("redir_inflight3", 32'(ready3), 32'h1);
      step(1'b1, 32'h0000_1002);
      expect_first_pc("redir_first_pc", 32'h0000_1000);
      repeat (15) step(1'b0, 32'h0);
    end

    // Redirect colliding with a response and a pop, then a second redirect.
    set_mode(1, 1, 100, 100);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        if (resp_due() && mq.size() != 0) hit = 1'b1;
        else step(1'b0, 32'h0);
      end
      check("double_redir_setup", 32'(hit), 32'h1);
      step(1'b1, 32'h0000_3000);
      step(1'b1, 32'h0000_0200);
      expect_first_pc("double_redir_pc", 32'h0000_0200);
      repeat (15) step(1'b0, 32'h0);
    end

    // Fetch PC wraps across the top of the address space.
    set_mode(1, 2, 80, 80);
    step(1'b1, 32'hFFFF_FFF5);
    expect_first_pc("wrap_first_pc", 32'hFFFF_FFF4);
    repeat (30) step(1'b0, 32'h0);

    // Random latency, backpressure and redirects.
    set_mode(1, 4, 60, 70);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(99) < 5) step(1'b1, $urandom);
      else                        step(1'b0, 32'h0);
    end

    // Reset in the middle of a burst.
    set_mode(2, 3, 100, 50);
    repeat (6) step(1'b0, 32'h0);
    rst = 1'b1;
    imem_resp_valid = 1'b0; redirect_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    check_reset_outputs("midrst");
    inflight.delete(); mq.delete();
    epoch++; fetch_m = 32'h0;
    @(negedge clk); @(negedge clk);
    cyc += 2; last_due = cyc;
    rst = 1'b0;
    set_mode(1, 3, 90, 90);
    repeat (40) step(1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
